// File: rtl/axi_lite_mem_master_if.sv
// -----------------------------------------------------------------------------
// axi_common / axi_lite_channel
//
// Purpose:
//   Shared AXI response encodings and the AXI-lite channel bundle that connects
//   an initiator (master modport) to a target (slave modport).
//
// Interface ports:
//   clk   - channel clock, shared by both ends
//   rstn  - asynchronous active-low reset, shared by both ends
//
// Channel signals (direction seen from the master):
//   AW: aw_valid/aw_addr/aw_prot out, aw_ready in
//   W : w_valid/w_data/w_strb out,    w_ready in
//   B : b_ready out,                  b_valid/b_resp in
//   AR: ar_valid/ar_addr/ar_prot out, ar_ready in
//   R : r_ready out,                  r_valid/r_data/r_resp in
// -----------------------------------------------------------------------------
package axi_common;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

interface axi_lite_channel #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic clk,
    input logic rstn
);
    // Write address channel
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    // Write data channel
    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    // Write response channel
    logic                    b_valid;
    logic                    b_ready;
    logic [1:0]              b_resp;
    // Read address channel
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    // Read data channel
    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;

    modport master (
        input  clk, rstn,
        output aw_valid, aw_addr, aw_prot,
        input  aw_ready,
        output w_valid, w_data, w_strb,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready,
        output ar_valid, ar_addr, ar_prot,
        input  ar_ready,
        input  r_valid, r_data, r_resp,
        output r_ready
    );

    modport slave (
        input  clk, rstn,
        input  aw_valid, aw_addr, aw_prot,
        output aw_ready,
        input  w_valid, w_data, w_strb,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready,
        input  ar_valid, ar_addr, ar_prot,
        output ar_ready,
        output r_valid, r_data, r_resp,
        input  r_ready
    );
endinterface

// File: rtl/axi_lite_mem_master.sv
// -----------------------------------------------------------------------------
// axi_lite_mem_master
//
// Purpose:
//   Bridges a simple single-port memory request/response interface onto an
//   AXI-lite initiator port. Exactly one transaction is in flight at a time:
//   a write (AW+W, then B) or a read (AR, then R). The response (read data and
//   an error flag) is registered and held until consumed.
//
// Ports:
//   clk         - clock (same net as master.clk)
//   rstn        - asynchronous active-low reset (same net as master.rstn)
//   req_valid   - request present
//   req_ready   - request accepted when high with req_valid (high only in IDLE)
//   req_we      - 1 = write, 0 = read
//   req_addr    - byte address; aligned down to the data-bus width on capture
//   req_strb    - write byte enables (ignored for reads)
//   req_wdata   - write data (ignored for reads)
//   resp_valid  - response present
//   resp_ready  - response consumed
//   resp_rdata  - read data, 0 for writes
//   resp_err    - B/R response was not OKAY
//   master      - AXI-lite initiator port
// -----------------------------------------------------------------------------
module axi_lite_mem_master #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    axi_lite_channel.master         master
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ADDR_LSB;

    // Widths must agree with the channel the block is bound to.
    if (DATA_WIDTH != master.DATA_WIDTH) begin : g_dw_mismatch
        $fatal(1, "axi_lite_mem_master: DATA_WIDTH differs from channel DATA_WIDTH");
    end
    if (ADDR_WIDTH != master.ADDR_WIDTH) begin : g_aw_mismatch
        $fatal(1, "axi_lite_mem_master: ADDR_WIDTH differs from channel ADDR_WIDTH");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_RESP,
        RESP
    } state_e;

    state_e                  state_q,      state_d;
    logic                    aw_valid_q,   aw_valid_d;
    logic                    w_valid_q,    w_valid_d;
    logic                    ar_valid_q,   ar_valid_d;
    logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic [STRB_WIDTH-1:0]   strb_q,       strb_d;
    logic [DATA_WIDTH-1:0]   wdata_q,      wdata_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q,   resp_err_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            addr_q       <= '0;
            strb_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            ar_valid_q   <= ar_valid_d;
            addr_q       <= addr_d;
            strb_q       <= strb_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        ar_valid_d   = ar_valid_q;
        addr_d       = addr_q;
        strb_d       = strb_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr & ADDR_MASK;
                    strb_d  = req_strb;
                    wdata_d = req_wdata;
                    if (req_we) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_ADDR;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_ADDR;
                    end
                end
            end

            WR_ADDR: begin
                // AW and W retire independently; leave once neither is still
                // pending after this edge, whatever order they completed in.
                aw_valid_d = aw_valid_q && !master.aw_ready;
                w_valid_d  = w_valid_q  && !master.w_ready;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d = WR_RESP;
                end
            end

            WR_RESP: begin
                if (master.b_valid) begin
                    resp_err_d   = (master.b_resp != axi_common::RESP_OKAY);
                    resp_rdata_d = '0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end

            RD_ADDR: begin
                if (master.ar_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = RD_RESP;
                end
            end

            RD_RESP: begin
                if (master.r_valid) begin
                    resp_err_d   = (master.r_resp != axi_common::RESP_OKAY);
                    resp_rdata_d = master.r_data;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end

            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: every AXI valid/ready is a register or a decode of state_q,
    // so nothing on the AXI inputs or req_valid reaches them combinationally.
    // ------------------------------------------------------------------
    assign req_ready       = (state_q == IDLE);

    assign master.aw_valid = aw_valid_q;
    assign master.aw_addr  = addr_q;
    assign master.aw_prot  = '0;

    assign master.w_valid  = w_valid_q;
    assign master.w_data   = wdata_q;
    assign master.w_strb   = strb_q;

    assign master.b_ready  = (state_q == WR_RESP);

    assign master.ar_valid = ar_valid_q;
    assign master.ar_addr  = addr_q;
    assign master.ar_prot  = '0;

    assign master.r_ready  = (state_q == RD_RESP);

    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_rdata      = resp_rdata_q;

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_mem_master
//
// Directed bench for axi_lite_mem_master. A small AXI-lite slave model with
// per-channel wait-state knobs and a word memory answers the DUT; monitors
// record handshake cycles so latencies can be checked against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_axi_lite_mem_master;

    localparam int DW = 64;
    localparam int AW = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [DW/8-1:0] req_strb;
    logic [DW-1:0]   req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [DW-1:0]   resp_rdata;
    logic            resp_err;

    axi_lite_channel #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m (.clk(clk), .rstn(rstn));

    axi_lite_mem_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_strb   (req_strb),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .master     (m)
    );

    // ---------------- slave configuration (written by the stimulus) -------
    int         aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0] b_resp_cfg = 2'b00;
    logic [1:0] r_resp_cfg = 2'b00;

    // ---------------- slave state and monitors --------------------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit   [63:0] mem [0:255];
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        have_aw, have_w, b_pend, r_pend, b_prev;
    logic [31:0] aw_addr_l;
    logic [63:0] w_data_l, r_data_l;
    logic [7:0]  w_strb_l;

    int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
    int          aw_fire_cyc = 0, w_fire_cyc = 0, ar_fire_cyc = 0, b_fire_cyc = 0;
    int          b_rise_cyc = 0, aw_vcyc = 0, w_vcyc = 0;
    logic [31:0] aw_addr_seen = '0, ar_addr_seen = '0;
    logic [7:0]  w_strb_seen = '0;
    logic [63:0] w_data_seen = '0;

    logic        aw_fire, w_fire, aw_got, w_got;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;
    assign aw_fire = m.aw_valid && m.aw_ready;
    assign w_fire  = m.w_valid && m.w_ready;
    assign aw_got  = have_aw || aw_fire;
    assign w_got   = have_w || w_fire;
    assign wr_addr = have_aw ? aw_addr_l : m.aw_addr;
    assign wr_data = have_w ? w_data_l : m.w_data;
    assign wr_strb = have_w ? w_strb_l : m.w_strb;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            have_aw <= 1'b0; have_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            b_prev <= 1'b0;
            aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0; r_data_l <= '0;
        end else begin
            if (m.aw_valid) begin
                aw_vcyc <= aw_vcyc + 1;
                if (m.aw_ready) begin
                    aw_hs <= aw_hs + 1; aw_fire_cyc <= cyc; aw_addr_seen <= m.aw_addr;
                    have_aw <= 1'b1; aw_addr_l <= m.aw_addr; aw_cnt <= 0;
                end else aw_cnt <= aw_cnt + 1;
            end
            if (m.w_valid) begin
                w_vcyc <= w_vcyc + 1;
                if (m.w_ready) begin
                    w_hs <= w_hs + 1; w_fire_cyc <= cyc;
                    w_strb_seen <= m.w_strb; w_data_seen <= m.w_data;
                    have_w <= 1'b1; w_data_l <= m.w_data; w_strb_l <= m.w_strb; w_cnt <= 0;
                end else w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !b_pend) begin
                mem[wr_addr[10:3]] <= merge(mem[wr_addr[10:3]], wr_data, wr_strb);
                have_aw <= 1'b0; have_w <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end
            if (b_pend) begin
                if (m.b_valid && m.b_ready) begin
                    b_pend <= 1'b0; b_hs <= b_hs + 1; b_fire_cyc <= cyc;
                end else if (!m.b_valid) b_cnt <= b_cnt + 1;
            end
            b_prev <= m.b_ready;
            if (m.b_ready && !b_prev) b_rise_cyc <= cyc;
            if (m.ar_valid) begin
                if (m.ar_ready) begin
                    ar_hs <= ar_hs + 1; ar_fire_cyc <= cyc; ar_addr_seen <= m.ar_addr;
                    r_pend <= 1'b1; r_cnt <= 0; r_data_l <= mem[m.ar_addr[10:3]]; ar_cnt <= 0;
                end else ar_cnt <= ar_cnt + 1;
            end
            if (r_pend) begin
                if (m.r_valid && m.r_ready) begin
                    r_pend <= 1'b0; r_hs <= r_hs + 1;
                end else if (!m.r_valid) r_cnt <= r_cnt + 1;
            end
        end
    end

    // Slave outputs change only on the falling edge.
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            m.aw_ready = 1'b0; m.w_ready = 1'b0; m.ar_ready = 1'b0;
            m.b_valid = 1'b0; m.b_resp = 2'b00;
            m.r_valid = 1'b0; m.r_resp = 2'b00; m.r_data = '0;
        end else begin
            m.aw_ready = m.aw_valid && (aw_cnt >= aw_dly);
            m.w_ready  = m.w_valid && (w_cnt >= w_dly);
            m.ar_ready = m.ar_valid && (ar_cnt >= ar_dly);
            m.b_valid  = b_pend && (b_cnt >= b_dly);
            m.b_resp   = b_resp_cfg;
            m.r_valid  = r_pend && (r_cnt >= r_dly);
            m.r_resp   = r_resp_cfg;
            m.r_data   = r_data_l;
        end
    end

    // ---------------- checking helpers -----------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int acc_cyc  = 0;
    int resp_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a falling edge; it is taken at the next rising edge.
    task automatic issue(input logic we, input logic [31:0] a, input logic [7:0] s,
                         input logic [63:0] d);
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_strb = s; req_wdata = d;
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for the response, hold resp_ready low for 'stall' cycles,
    // then consume it and confirm the block is back in IDLE.
    task automatic wait_resp(input int stall, input logic [63:0] exp_rdata,
                             input logic exp_err, input int exp_lat);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            check("req_ready_busy", {63'd0, req_ready}, 64'd0);
            @(negedge clk);
            n++;
        end
        check("resp_valid_seen", {63'd0, resp_valid}, 64'd1);
        resp_cyc = cyc;
        check("resp_latency", 64'(resp_cyc - acc_cyc), 64'(exp_lat));
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", {63'd0, resp_err}, {63'd0, exp_err});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
            check("stall_rdata", resp_rdata, exp_rdata);
            check("stall_err", {63'd0, resp_err}, {63'd0, exp_err});
            check("stall_req_ready", {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("idle_after_resp", {63'd0, req_ready}, 64'd1);
        check("resp_valid_cleared", {63'd0, resp_valid}, 64'd0);
    endtask

    // ---------------- stimulus --------------------------------------------
    logic        bb_we   [4];
    logic [31:0] bb_addr [4];
    logic [7:0]  bb_strb [4];
    logic [63:0] bb_data [4];
    logic [63:0] bb_rd   [4];
    logic        bb_err  [4];
    int          bb_acc  [4];

    initial begin
        int aw0, w0, av0, wv0, ar0, nresp, idx, extra;

        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_strb = '0; req_wdata = '0;
        resp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_aw_valid", {63'd0, m.aw_valid}, 64'd0);
        check("rst_w_valid", {63'd0, m.w_valid}, 64'd0);
        check("rst_ar_valid", {63'd0, m.ar_valid}, 64'd0);
        check("rst_b_ready", {63'd0, m.b_ready}, 64'd0);
        check("rst_r_ready", {63'd0, m.r_ready}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_err", {63'd0, resp_err}, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: minimum write, address aligned down, strobes passed through
        issue(1'b1, 32'h0000_1004, 8'hF0, 64'hDEADBEEF_CAFEF00D);
        wait_resp(0, 64'd0, 1'b0, 3);
        check("t1_aw_cycle", 64'(aw_fire_cyc - acc_cyc), 64'd1);
        check("t1_w_cycle", 64'(w_fire_cyc - acc_cyc), 64'd1);
        check("t1_b_cycle", 64'(b_fire_cyc - acc_cyc), 64'd2);
        check("t1_aw_addr", {32'd0, aw_addr_seen}, 64'h1000);
        check("t1_w_strb", {56'd0, w_strb_seen}, 64'hF0);
        check("t1_w_data", w_data_seen, 64'hDEADBEEF_CAFEF00D);

        // 2: AW ready at once, W held off three cycles
        w_dly = 3;
        aw0 = aw_hs; w0 = w_hs; av0 = aw_vcyc; wv0 = w_vcyc;
        issue(1'b1, 32'h0000_1008, 8'hFF, 64'h1111_2222_3333_4444);
        wait_resp(0, 64'd0, 1'b0, 6);
        check("t2_aw_cycle", 64'(aw_fire_cyc - acc_cyc), 64'd1);
        check("t2_w_cycle", 64'(w_fire_cyc - acc_cyc), 64'd4);
        check("t2_aw_valid_cycles", 64'(aw_vcyc - av0), 64'd1);
        check("t2_w_valid_cycles", 64'(w_vcyc - wv0), 64'd4);
        check("t2_b_ready_rise", 64'(b_rise_cyc - acc_cyc), 64'd5);
        check("t2_aw_count", 64'(aw_hs - aw0), 64'd1);
        check("t2_w_count", 64'(w_hs - w0), 64'd1);
        w_dly = 0;

        // 3: read with late R and a stalled consumer
        issue(1'b1, 32'h0000_0020, 8'hFF, 64'h0123456789ABCDEF);
        wait_resp(0, 64'd0, 1'b0, 3);
        r_dly = 2;
        ar0 = ar_hs;
        issue(1'b0, 32'h0000_0020, 8'h00, 64'd0);
        wait_resp(3, 64'h0123456789ABCDEF, 1'b0, 5);
        check("t3_ar_addr", {32'd0, ar_addr_seen}, 64'h20);
        check("t3_ar_count", 64'(ar_hs - ar0), 64'd1);
        check("t3_ar_cycle", 64'(ar_fire_cyc - acc_cyc), 64'd1);
        r_dly = 0;

        // 4: error responses are reported and do not stall the block
        r_resp_cfg = 2'b10;
        issue(1'b0, 32'h0000_1000, 8'h00, 64'd0);
        wait_resp(0, 64'hDEADBEEF_00000000, 1'b1, 3);
        r_resp_cfg = 2'b00;
        b_resp_cfg = 2'b11;
        issue(1'b1, 32'h0000_1010, 8'hFF, 64'h5555_6666_7777_8888);
        wait_resp(0, 64'd0, 1'b1, 3);
        b_resp_cfg = 2'b00;
        issue(1'b0, 32'h0000_1000, 8'h00, 64'd0);
        wait_resp(0, 64'hDEADBEEF_00000000, 1'b0, 3);

        // 5: req_valid held high, alternating write/read to one word
        bb_we[0] = 1'b1; bb_addr[0] = 32'h40; bb_strb[0] = 8'hFF; bb_data[0] = 64'hAAAA_BBBB_CCCC_DDDD;
        bb_we[1] = 1'b0; bb_addr[1] = 32'h40; bb_strb[1] = 8'h00; bb_data[1] = 64'd0;
        bb_we[2] = 1'b1; bb_addr[2] = 32'h44; bb_strb[2] = 8'h0F; bb_data[2] = 64'h1111_2222_3333_4444;
        bb_we[3] = 1'b0; bb_addr[3] = 32'h40; bb_strb[3] = 8'h00; bb_data[3] = 64'd0;
        for (int i = 0; i < 4; i++) begin bb_rd[i] = 'x; bb_err[i] = 1'bx; bb_acc[i] = 0; end
        resp_ready = 1'b1;
        idx = 0; nresp = 0;
        req_valid = 1'b1; req_we = bb_we[0]; req_addr = bb_addr[0];
        req_strb = bb_strb[0]; req_wdata = bb_data[0];
        for (int t = 0; t < 40 && nresp < 4; t++) begin
            if (resp_valid === 1'b1) begin
                bb_rd[nresp] = resp_rdata; bb_err[nresp] = resp_err; nresp++;
            end
            if (req_ready === 1'b1 && idx < 4) begin
                bb_acc[idx] = cyc; idx++;
            end
            @(negedge clk);
            if (idx < 4) begin
                req_we = bb_we[idx]; req_addr = bb_addr[idx];
                req_strb = bb_strb[idx]; req_wdata = bb_data[idx];
            end else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        extra = 0;
        for (int t = 0; t < 6; t++) begin
            if (resp_valid === 1'b1) extra++;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        check("t5_resp_count", 64'(nresp + extra), 64'd4);
        check("t5_accept_gap1", 64'(bb_acc[1] - bb_acc[0]), 64'd4);
        check("t5_accept_gap2", 64'(bb_acc[2] - bb_acc[1]), 64'd4);
        check("t5_accept_gap3", 64'(bb_acc[3] - bb_acc[2]), 64'd4);
        check("t5_resp0_rdata", bb_rd[0], 64'd0);
        check("t5_resp1_rdata", bb_rd[1], 64'hAAAA_BBBB_CCCC_DDDD);
        check("t5_resp2_rdata", bb_rd[2], 64'd0);
        check("t5_resp3_rdata", bb_rd[3], 64'hAAAA_BBBB_3333_4444);
        check("t5_resp_errs", {60'd0, bb_err[3], bb_err[2], bb_err[1], bb_err[0]}, 64'd0);

        // 6: asynchronous reset while waiting for B
        b_dly = 5;
        issue(1'b1, 32'h0000_0048, 8'hFF, 64'hFFFF_0000_FFFF_0000);
        @(negedge clk);
        check("t6_in_wr_resp", {63'd0, m.b_ready}, 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_b_ready", {63'd0, m.b_ready}, 64'd0);
        check("t6_rst_valids", {61'd0, m.aw_valid, m.w_valid, m.ar_valid}, 64'd0);
        check("t6_rst_r_ready", {63'd0, m.r_ready}, 64'd0);
        check("t6_rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("t6_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("t6_req_ready_after", {63'd0, req_ready}, 64'd1);
        extra = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) extra++;
        end
        check("t6_no_stray_resp", 64'(extra), 64'd0);
        b_dly = 0;

        // Block is usable again after reset
        issue(1'b0, 32'h0000_0040, 8'h00, 64'd0);
        wait_resp(0, 64'hAAAA_BBBB_3333_4444, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_lite_mem_master.md
# axi_lite_mem_master

Converts a simple single-port memory request/response interface into AXI-lite master transactions, so that simple cores and DMA-style engines can reach AXI-lite slaves. It sits on the initiator side of an `axi_lite_channel`. It issues exactly one transaction at a time, either a write (AW+W, then B) or a read (AR, then R). It returns a registered response carrying read data and an error flag.

## Interface
- `DATA_WIDTH`, 64: data width in bits; must equal `master.DATA_WIDTH`, otherwise `$fatal`.
- `ADDR_WIDTH`, 32: byte-address width; must equal `master.ADDR_WIDTH`, otherwise `$fatal`.
- `clk`  in  1  clock; the same net as `master.clk`.
- `rstn`  in  1  reset, asynchronous, active-low; the same net as `master.rstn`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_strb`  in  DATA_WIDTH/8  write byte enables; ignored for reads.
- `req_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  response consumed.
- `resp_rdata`  out  DATA_WIDTH  read data; 0 for writes.
- `resp_err`  out  1  1 if B/R resp != `axi_common::RESP_OKAY`.
- `master`  `axi_lite_channel.master`  AXI-lite initiator port.

## Operation
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch the request into registers.
  - Address is latched with its low `$clog2(DATA_WIDTH/8)` bits forced to 0.
  - Go to WR_ADDR if `req_we`=1, else RD_ADDR.
  - In the same edge, set `aw_valid`+`w_valid` (write) or `ar_valid` (read).
- WR_ADDR:
  - `aw_valid` and `w_valid` are independent registers.
  - Each clears on its own handshake; `aw_valid` and `w_valid` may complete in any order or in the same cycle.
  - When both have completed (including the completing edge), go to WR_RESP.
- WR_RESP:
  - `b_ready`=1.
  - On `b_valid`: `resp_err`<=(`b_resp`!=OKAY), `resp_rdata`<=0, `resp_valid`<=1, go to RESP.
- RD_ADDR: `ar_valid` held until `ar_ready`, then cleared; go to RD_RESP.
- RD_RESP:
  - `r_ready`=1.
  - On `r_valid`: `resp_rdata`<=`r_data`, `resp_err`<=(`r_resp`!=OKAY), `resp_valid`<=1, go to RESP.
- RESP: hold `resp_*` stable until `resp_ready`; then `resp_valid`<=0 and go to IDLE.
- `b_ready` is 0 outside WR_RESP; `r_ready` is 0 outside RD_RESP.
- `aw_addr`/`ar_addr`/`w_data`/`w_strb` come from the latched registers and are stable while the corresponding valid is high.
- All other AW/AR sideband fields are driven to 0.
- No combinational path from any AXI input to any AXI valid/ready output.
- No combinational path from `req_valid` to any AXI output.
- Errors do not stall the block; SLVERR/DECERR are reported once via `resp_err` and the FSM returns to IDLE normally.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `aw_valid`=`w_valid`=`ar_valid`=0, `b_ready`=`r_ready`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
- Reset asserted mid-transaction returns to IDLE immediately (asynchronous). The slave shares `rstn`, so no AXI completion is owed.
- Minimum write with a zero-wait slave:
  - cycle 0: request accepted.
  - cycle 1: AW and W fire.
  - cycle 2: B fires.
  - cycle 3: `resp_valid`=1.
  - If `resp_ready`=1 in cycle 3, `req_ready`=1 in cycle 4.
- Minimum read: cycle 1 AR fires, cycle 2 R fires, cycle 3 `resp_valid`.
- Peak throughput: one transaction per 4 cycles.
- Stalls:
  - Each slave wait cycle on AW, W, AR, B or R adds one cycle.
  - Each cycle `resp_ready` is low in RESP adds one cycle.
- `req_ready` is 0 in every state except IDLE.
- The block never has more than one outstanding transaction.

## Test plan
- Write addr=0x1004, wdata=0xDEADBEEF_CAFEF00D, strb=0xF0, slave always ready with B OKAY:
  - AW fires cycle 1 with `aw_addr`=0x1000, and W fires cycle 1 with `w_strb`=0xF0.
  - `resp_valid`=1 cycle 3 with `resp_err`=0 and `resp_rdata`=0.
- Write where `aw_ready`=1 immediately but `w_ready` is delayed 3 cycles:
  - `aw_valid` drops after cycle 1; `w_valid` is held through cycle 4.
  - `b_ready` rises only in cycle 5; exactly one AW and one W handshake occur.
- Read addr=0x20, slave returns R 2 cycles late with data=0x0123456789ABCDEF, `resp_ready` low for 3 cycles:
  - `resp_rdata`/`resp_err` are stable while stalled, and `req_ready`=0 throughout.
- Read answered with `r_resp`=SLVERR, then a write answered with B DECERR:
  - `resp_err`=1 for both.
  - The FSM returns to IDLE after each, and the following OKAY read gives `resp_err`=0.
- `req_valid` held high with 4 alternating write/read requests to the same address, slave always ready:
  - Exactly 4 responses, in order; the read returns the data of the preceding write.
  - New requests are accepted only every 4th cycle.
- `rstn` pulsed low while in WR_RESP:
  - All valids/readys drop asynchronously, and `resp_valid` never asserts for that request.
  - `req_ready`=1 on the first cycle after release.
